// File: rtl/uart_boot_loader.sv
// UART boot loader: parses an A5 | LEN | data | CHK frame and writes the image word-by-word into memory
// while holding the CPU in reset. Define BOOT_LOADER_ECHO_EN to echo accepted bytes on tx_data/tx_valid.
module uart_boot_loader #(
    parameter int AWIDTH         = 14,
    parameter int BASE_WORD      = 0,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              boot_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              cpu_n_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        tx_data,
    output logic              tx_valid
);
    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [32:0] MEM_WORDS = 33'd1 << AWIDTH;
    localparam logic [32:0] BASE_EXT  = 33'(BASE_WORD);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {IDLE, SYNC, LEN0, LEN1, DATA, CHK, ERR} state_t;

    state_t        state, state_nx;
    logic [7:0]    len_lo;
    logic [15:0]   len, len_rx, word_idx;
    logic [1:0]    byte_cnt;
    logic [31:0]   word_buf;
    logic [7:0]    sum;
    logic [TW-1:0] timer;
    logic          in_frame, timed_out, len_bad, last_word, chk_ok;

    // The length check is done in 33 bits so BASE_WORD + LEN can never wrap before the compare.
    always_comb begin
        in_frame  = state inside {LEN0, LEN1, DATA, CHK};
        timed_out = in_frame && !rx_valid && (timer == TW'(TIMEOUT_CYCLES - 1));
        len_rx    = {rx_data, len_lo};
        len_bad   = (len_rx == 16'd0) || ((BASE_EXT + 33'(len_rx)) > MEM_WORDS);
        last_word = (word_idx == len - 16'd1);
        chk_ok    = (rx_data == sum);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        unique case (state)
            IDLE: if (boot_req) state_nx = SYNC;
            SYNC: begin
                busy = 1'b1;
                if (rx_valid && rx_data == SYNC_BYTE) state_nx = LEN0;
            end
            LEN0: begin
                busy = 1'b1;
                if (rx_valid) state_nx = LEN1;
            end
            LEN1: begin
                busy = 1'b1;
                if (rx_valid) state_nx = len_bad ? ERR : DATA;
            end
            DATA: begin
                busy = 1'b1;
                if (rx_valid && byte_cnt == 2'd3 && last_word) state_nx = CHK;
            end
            CHK: begin
                busy = 1'b1;
                if (rx_valid) state_nx = chk_ok ? IDLE : ERR;
            end
            ERR: if (boot_req) state_nx = SYNC;
            default: state_nx = IDLE;
        endcase
        if (timed_out) state_nx = ERR;
    end

    // Frame datapath; err and cpu_n_rst follow the next state so they change on the transition edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            len_lo    <= 8'h00;
            len       <= 16'h0000;
            word_idx  <= 16'h0000;
            byte_cnt  <= 2'd0;
            word_buf  <= 32'h0000_0000;
            sum       <= 8'h00;
            timer     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            cpu_n_rst <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            done      <= (state == CHK) && rx_valid && chk_ok;
            err       <= (state_nx == ERR);
            cpu_n_rst <= (state_nx == IDLE);
            timer     <= (!in_frame || rx_valid) ? '0 : timer + TW'(1);
            unique case (state)
                SYNC: begin
                    sum      <= 8'h00;
                    byte_cnt <= 2'd0;
                    word_idx <= 16'h0000;
                end
                LEN0: if (rx_valid) len_lo <= rx_data;
                LEN1: if (rx_valid) len <= len_rx;
                DATA: if (rx_valid) begin
                    word_buf[{byte_cnt, 3'b000} +: 8] <= rx_data;
                    sum      <= sum + rx_data;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        mem_we   <= 1'b1;
                        mem_addr <= AWIDTH'(BASE_EXT + 33'(word_idx));
                        word_idx <= word_idx + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_wdata = word_buf;
    assign mem_be    = {4{mem_we}};

`ifdef BOOT_LOADER_ECHO_EN
    logic echo_byte, enter_err, bang_pending;

    always_comb begin
        echo_byte = rx_valid && (state != IDLE) && (state != ERR);
        enter_err = (state_nx == ERR) && (state != ERR);
    end

    // An ERR entry caused by a received byte queues the '!' behind that byte's own echo.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_data      <= 8'h00;
            tx_valid     <= 1'b0;
            bang_pending <= 1'b0;
        end else if (echo_byte) begin
            tx_data      <= rx_data;
            tx_valid     <= 1'b1;
            bang_pending <= enter_err;
        end else if (enter_err || bang_pending) begin
            tx_data      <= 8'h21;
            tx_valid     <= 1'b1;
            bang_pending <= 1'b0;
        end else begin
            tx_valid     <= 1'b0;
        end
    end
`else
    assign tx_data  = 8'h00;
    assign tx_valid = 1'b0;
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed and random frames checked against a frame-level
// reference model of writes, checksum outcome and inter-byte timeouts.
module tb_uart_boot_loader;
    localparam int AW   = 14;
    localparam int BASE = 16368;
    localparam int TO   = 100;

    logic          clk = 1'b0;
    logic          n_rst, boot_req, rx_valid;
    logic [7:0]    rx_data;
    logic          mem_we, cpu_n_rst, busy, done, err, tx_valid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [7:0]    tx_data;

    uart_boot_loader #(.AWIDTH(AW), .BASE_WORD(BASE), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .n_rst(n_rst), .boot_req(boot_req), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .cpu_n_rst(cpu_n_rst), .busy(busy), .done(done), .err(err),
        .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt++;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Observed DUT activity
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cnt = 0;
    int          tx_cnt   = 0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(32'(mem_addr));
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cycle_cnt);
            checkOutput("mem_be", 32'(mem_be), 32'h0000_000F);
        end
        if (done === 1'b1) begin
            done_cnt++;
            checkOutput("cpu_rst_with_done", 32'(cpu_n_rst), 32'd1);
        end
        if (tx_valid === 1'b1) tx_cnt++;
    end

    // Frame under test and the cycle each byte was driven in
    logic [7:0]  fb[$];
    int          fg[$];
    int          dc[$];

    // Reference model results
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_pos[$];
    bit          exp_done, exp_err;
    int          n_acc;

    // Walk the frame: locate A5, find the first gap long enough to time out, then decide the outcome.
    function automatic void runModel();
        int         a, tpos, len, p0, cp;
        logic [7:0] s;
        exp_addr.delete(); exp_data.delete(); exp_pos.delete();
        exp_done = 1'b0; exp_err = 1'b0; n_acc = 0;
        a = 0;
        while (a < fb.size() && fb[a] != 8'hA5) a++;
        tpos = fb.size();
        for (int p = fb.size() - 1; p > a; p--) if (fg[p] >= TO) tpos = p;
        if (tpos < a + 3) begin exp_err = 1'b1; n_acc = tpos; return; end
        len = {fb[a+2], fb[a+1]};
        if (len == 0 || BASE + len > (1 << AW)) begin exp_err = 1'b1; n_acc = a + 3; return; end
        s = 8'h00;
        for (int w = 0; w < len; w++) begin
            p0 = a + 3 + 4 * w;
            if (p0 + 3 >= tpos) begin exp_err = 1'b1; n_acc = tpos; return; end
            exp_addr.push_back(32'((BASE + w) % (1 << AW)));
            exp_data.push_back({fb[p0+3], fb[p0+2], fb[p0+1], fb[p0]});
            exp_pos.push_back(p0 + 3);
            s = s + fb[p0] + fb[p0+1] + fb[p0+2] + fb[p0+3];
        end
        cp = a + 3 + 4 * len;
        if (cp >= tpos) begin exp_err = 1'b1; n_acc = tpos; return; end
        n_acc = cp + 1;
        if (fb[cp] == s) exp_done = 1'b1;
        else             exp_err  = 1'b1;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap, input bit boot);
        waitCycles(gap);
        rx_data  = b;
        rx_valid = 1'b1;
        boot_req = boot;
        dc.push_back(cycle_cnt);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        boot_req = 1'b0;
    endtask

    task automatic clearMon();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); dc.delete();
        done_cnt = 0;
        tx_cnt   = 0;
    endtask

    task automatic makeFrame(input int garbage, input logic [15:0] len, input int nwords, input bit bad_chk);
        logic [7:0] g, s;
        fb.delete(); fg.delete();
        repeat (garbage) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            fb.push_back(g); fg.push_back(int'($urandom_range(0, 5)));
        end
        fb.push_back(8'hA5);     fg.push_back(int'($urandom_range(0, 2)));
        fb.push_back(len[7:0]);  fg.push_back(int'($urandom_range(0, 2)));
        fb.push_back(len[15:8]); fg.push_back(int'($urandom_range(0, 2)));
        s = 8'h00;
        repeat (nwords * 4) begin
            g = 8'($urandom_range(0, 255));
            s = s + g;
            fb.push_back(g); fg.push_back(int'($urandom_range(0, 2)));
        end
        if (nwords > 0) begin
            fb.push_back(bad_chk ? s + 8'($urandom_range(1, 255)) : s);
            fg.push_back(int'($urandom_range(0, 2)));
        end
    endtask

    task automatic applyStimulus(input string name);
        runModel();
        @(posedge clk); #1; boot_req = 1'b1;
        @(posedge clk); #1; boot_req = 1'b0;
        checkOutput({name, ":busy_after_boot"}, 32'(busy), 32'd1);
        checkOutput({name, ":err_after_boot"}, 32'(err), 32'd0);
        checkOutput({name, ":cpu_held"}, 32'(cpu_n_rst), 32'd0);
        clearMon();
        for (int p = 0; p < fb.size(); p++)
            sendByte(fb[p], fg[p], (p < n_acc) ? bit'($urandom_range(0, 1)) : 1'b0);
        waitCycles(4);
        checkOutput({name, ":wr_cnt"}, 32'(wr_addr_q.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < wr_addr_q.size()) begin
                checkOutput($sformatf("%s:addr%0d", name, i), wr_addr_q[i], exp_addr[i]);
                checkOutput($sformatf("%s:data%0d", name, i), wr_data_q[i], exp_data[i]);
                checkOutput($sformatf("%s:lat%0d", name, i), 32'(wr_cyc_q[i] - dc[exp_pos[i]]), 32'd1);
            end
        end
        checkOutput({name, ":done_cnt"}, 32'(done_cnt), 32'(exp_done));
        checkOutput({name, ":err"}, 32'(err), 32'(exp_err));
        checkOutput({name, ":cpu_n_rst"}, 32'(cpu_n_rst), 32'(exp_done));
        checkOutput({name, ":busy_end"}, 32'(busy), 32'd0);
`ifdef BOOT_LOADER_ECHO_EN
        checkOutput({name, ":echo_cnt"}, 32'(tx_cnt), 32'(n_acc + int'(exp_err)));
`else
        checkOutput({name, ":tx_quiet"}, 32'(tx_cnt), 32'd0);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] s;
        int         kind, g, n;
        n_rst = 1'b0; boot_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #1;
        checkOutput("rst_outputs", {mem_we, busy, done, err, tx_valid, cpu_n_rst, mem_be},
                    32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);

        waitCycles(3);
        n_rst = 1'b1;
        checkOutput("rel_cpu_held", 32'(cpu_n_rst), 32'd0);
        waitCycles(1);
        checkOutput("rel_cpu_run", 32'(cpu_n_rst), 32'd1);

        // Bytes arriving while idle must be ignored
        clearMon();
        sendByte(8'hA5, 0, 1'b0); sendByte(8'h01, 0, 1'b0); sendByte(8'h00, 1, 1'b0);
        for (int i = 0; i < 5; i++) sendByte(8'($urandom_range(0, 255)), 0, 1'b0);
        waitCycles(3);
        checkOutput("idle_no_write", 32'(wr_addr_q.size()), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Reference image: two words, good then corrupted checksum
        fb = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        fg.delete();
        for (int i = 0; i < fb.size(); i++) fg.push_back(0);
        s = 8'h00;
        for (int i = 3; i < 11; i++) s = s + fb[i];
        fb[11] = s;
        applyStimulus("spec_ok");
        if (wr_data_q.size() == 2) begin
            checkOutput("spec_w0", wr_data_q[0], 32'h1234_5678);
            checkOutput("spec_w1", wr_data_q[1], 32'hDEAD_BEEF);
            checkOutput("spec_a1", wr_addr_q[1], 32'(BASE + 1));
        end
        fb[11] = s + 8'h01;
        applyStimulus("spec_badchk");

        makeFrame(0, 16'h0000, 0, 1'b0);  applyStimulus("len_zero");
        makeFrame(2, 16'h4001, 0, 1'b0);  applyStimulus("len_4001");
        makeFrame(0, 16'd17, 0, 1'b0);    applyStimulus("len_over");
        makeFrame(1, 16'd16, 16, 1'b0);   applyStimulus("len_max");

        makeFrame(0, 16'd3, 3, 1'b0); fg[8] = TO;     applyStimulus("tmo_data");
        makeFrame(0, 16'd3, 3, 1'b0); fg[8] = TO - 1; applyStimulus("tmo_edge");
        makeFrame(0, 16'd2, 2, 1'b0); fg[2] = TO + 3; applyStimulus("tmo_len1");

        for (int f = 0; f < 30; f++) begin
            kind = int'($urandom_range(0, 7));
            g    = int'($urandom_range(0, 3));
            n    = int'($urandom_range(1, 5));
            if (kind == 0) begin
                if ($urandom_range(0, 1) == 0) makeFrame(g, 16'd0, 0, 1'b0);
                else makeFrame(g, 16'($urandom_range(17, 65535)), 0, 1'b0);
            end else begin
                makeFrame(g, 16'(n), n, $urandom_range(0, 3) == 0);
                if (kind == 1) fg[$urandom_range(g + 1, fb.size() - 1)] = TO + int'($urandom_range(0, 3));
                if (kind == 2) fg[$urandom_range(g + 1, fb.size() - 1)] = TO - 1;
            end
            applyStimulus($sformatf("rnd%0d", f));
        end

        // Asynchronous reset two bytes into the data phase
        @(posedge clk); #1; boot_req = 1'b1;
        @(posedge clk); #1; boot_req = 1'b0;
        clearMon();
        sendByte(8'hA5, 0, 1'b0); sendByte(8'h02, 0, 1'b0); sendByte(8'h00, 0, 1'b0);
        sendByte(8'h11, 0, 1'b0); sendByte(8'h22, 0, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_cpu", 32'(cpu_n_rst), 32'd0);
        checkOutput("mid_rst_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        sendByte(8'h33, 0, 1'b0); sendByte(8'h44, 0, 1'b0);
        waitCycles(2);
        checkOutput("mid_rst_no_write", 32'(wr_addr_q.size()), 32'd0);
        n_rst = 1'b1;
        checkOutput("mid_rel_cpu_held", 32'(cpu_n_rst), 32'd0);
        waitCycles(1);
        checkOutput("mid_rel_cpu_run", 32'(cpu_n_rst), 32'd1);
        checkOutput("mid_rel_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
